// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port unified memory: data has priority,
// a streak counter guarantees fetch progress, and a BUSY timeout aborts hung accesses.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_done,
  output logic                    if_err,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_done,
  output logic                    d_err,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic                    mem_rd_en,
  output logic                    mem_wr_en,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready
);

  localparam int SW  = DATA_WIDTH / 8;
  localparam int SCW = $clog2(STARVE_LIMIT + 2);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [SCW-1:0] STREAK_MAX = SCW'(STARVE_LIMIT);
  localparam logic [TCW-1:0] TO_LAST    = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t                state_q, state_d;
  logic [SCW-1:0]        streak_q, streak_d;
  logic [TCW-1:0]        tcnt_q, tcnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [SW-1:0]         mem_wstrb_q, mem_wstrb_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  if_done_q, if_done_d;
  logic                  if_err_q, if_err_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  d_done_q, d_done_d;
  logic                  d_err_q, d_err_d;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tcnt_d      = tcnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_rd_en_d = mem_rd_en_q;
    mem_wr_en_d = mem_wr_en_q;
    if_rdata_d  = if_rdata_q;
    if_done_d   = 1'b0;
    if_err_d    = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_done_d    = 1'b0;
    d_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        // Data wins unless fetch is waiting and data already had its streak.
        if (d_req && (!if_req || streak_q < STREAK_MAX)) begin
          state_d     = BUSY_D;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wstrb_d = d_wstrb;
          mem_rd_en_d = !d_we;
          mem_wr_en_d = d_we;
          streak_d    = if_req ? streak_q + 1'b1 : '0;
        end else if (if_req) begin
          state_d     = BUSY_I;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
          mem_rd_en_d = 1'b1;
          mem_wr_en_d = 1'b0;
          streak_d    = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        tcnt_d = tcnt_q + 1'b1;
        if (mem_ready || tcnt_q == TO_LAST) begin
          state_d     = DONE;
          mem_rd_en_d = 1'b0;
          mem_wr_en_d = 1'b0;
          if (state_q == BUSY_I) begin
            if_done_d  = 1'b1;
            if_err_d   = !mem_ready;
            if_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            d_done_d = 1'b1;
            d_err_d  = !mem_ready;
            if (mem_rd_en_q) d_rdata_d = mem_ready ? mem_rdata : '0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      tcnt_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      if_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      d_rdata_q   <= '0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      tcnt_q      <= tcnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      if_rdata_q  <= if_rdata_d;
      if_done_q   <= if_done_d;
      if_err_q    <= if_err_d;
      d_rdata_q   <= d_rdata_d;
      d_done_q    <= d_done_d;
      d_err_q     <= d_err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_wr_en = mem_wr_en_q;
  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign if_err    = if_err_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transactions against a memory responder,
// plus grant-order, timeout, DONE-phase request and async-reset sequences.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, SW = 4, SL = 4, TO = 8;

  logic          clk = 1'b0, rst = 1'b0;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [SW-1:0] d_wstrb = '0;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_wstrb;
  logic          if_done, if_err, d_done, d_err, mem_rd_en, mem_wr_en;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          dly;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } txn_t;

  typedef struct {
    bit          is_d;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m[logic [31:0]];
  int          checks = 0, errors = 0;
  int          rsp_dly = 1, bcnt = 0;
  bit          rsp_force = 1'b0;

  // Memory responder: raises mem_ready after rsp_dly enabled cycles (never if larger than the timeout).
  always @(negedge clk) begin
    if (mem_rd_en || mem_wr_en) begin
      bcnt = bcnt + 1;
      if (bcnt == rsp_dly) begin
        logic [31:0] cur;
        cur = mem_m.exists(mem_addr) ? mem_m[mem_addr] : 32'h0;
        mem_rdata = cur;
        if (mem_wr_en) begin
          for (int b = 0; b < 4; b++) if (mem_wstrb[b]) cur[b*8 +: 8] = mem_wdata[b*8 +: 8];
          mem_m[mem_addr] = cur;
        end
        mem_ready = 1'b1;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'h5A5A5A5A;
      end
    end else begin
      bcnt      = 0;
      mem_ready = rsp_force;
      mem_rdata = 32'h5A5A5A5A;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic txn_t mk(bit is_d, bit we, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] wstrb, int dly, bit err, logic [31:0] rd);
    txn_t t;
    t.is_d = is_d; t.we = we; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb;
    t.dly = dly; t.exp_err = err; t.exp_rdata = rd;
    return t;
  endfunction

  task automatic run_txn(input txn_t t, input int idx);
    exp_t        e, g;
    bit          seen_en = 0, stable = 1, done = 0;
    int          en_cyc = 0;
    logic [31:0] a0 = '0, w0 = '0;
    logic [3:0]  s0 = '0;
    logic        r0 = 1'b0, we0 = 1'b0;
    string       p;
    p = $sformatf("txn%0d", idx);
    rsp_dly = t.dly;
    if (t.is_d) begin
      d_req = 1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata; d_wstrb = t.wstrb;
    end else begin
      if_req = 1; if_addr = t.addr;
    end
    e.is_d = t.is_d; e.err = t.exp_err; e.rdata = t.exp_rdata;
    exp_q.push_back(e);
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (mem_rd_en || mem_wr_en) begin
        en_cyc++;
        if (!seen_en) begin
          seen_en = 1; a0 = mem_addr; w0 = mem_wdata; s0 = mem_wstrb; r0 = mem_rd_en; we0 = mem_wr_en;
          // Wiggle the held request: the latched transaction must not follow it.
          if (t.is_d) begin d_addr = ~t.addr; d_wdata = ~t.wdata; end
          else if_addr = ~t.addr;
        end else if ({mem_addr, mem_wdata, mem_wstrb, mem_rd_en, mem_wr_en} !== {a0, w0, s0, r0, we0})
          stable = 0;
      end
      if (if_done || d_done) begin
        done = 1;
        if (exp_q.size() == 0) begin
          chk({p, "_unexpected_done"}, 32'(1), 32'(0));
        end else begin
          g = exp_q.pop_front();
          chk({p, "_port"}, 32'({if_done, d_done}), g.is_d ? 32'h1 : 32'h2);
          chk({p, "_err"}, 32'(g.is_d ? d_err : if_err), 32'(g.err));
          chk({p, "_rdata"}, g.is_d ? d_rdata : if_rdata, g.rdata);
        end
        if_req = 0; d_req = 0;
      end
    end
    if (!done) begin
      chk({p, "_done_timeout"}, 32'(0), 32'(1));
      if_req = 0; d_req = 0;
      exp_q.delete();
    end
    chk({p, "_mem_addr"}, a0, t.addr);
    chk({p, "_mem_wdata"}, w0, t.is_d ? t.wdata : 32'h0);
    chk({p, "_mem_wstrb"}, 32'(s0), t.is_d ? 32'(t.wstrb) : 32'h0);
    chk({p, "_rd_wr_en"}, 32'({r0, we0}), (t.is_d && t.we) ? 32'h1 : 32'h2);
    chk({p, "_mem_stable"}, 32'(stable), 32'(1));
    chk({p, "_en_cycles"}, 32'(en_cyc), t.exp_err ? 32'(TO) : 32'(t.dly));
    @(negedge clk);
    chk({p, "_done_pulse_1cyc"}, 32'({if_done, d_done}), 32'h0);
  endtask

  txn_t tbl[11];

  initial begin
    logic [0:9] exp_ord;
    logic [0:9] got_ord;
    int         ng;
    bit         pe, en, seen_d, seen_i;

    mem_m[32'h100] = 32'hDEADBEEF;
    mem_m[32'h10]  = 32'h0000000D;
    mem_m[32'h300] = 32'h12345678;

    tbl[0]  = mk(0, 0, 32'h100,  32'h0,        4'h0, 1,   0, 32'hDEADBEEF);
    tbl[1]  = mk(1, 0, 32'h10,   32'h0,        4'h0, 2,   0, 32'h0000000D);
    tbl[2]  = mk(1, 1, 32'h2000, 32'h0003FFFF, 4'hF, 3,   0, 32'h0000000D);
    tbl[3]  = mk(1, 0, 32'h2000, 32'h0,        4'h0, 1,   0, 32'h0003FFFF);
    tbl[4]  = mk(1, 1, 32'h2000, 32'hAABBCCDD, 4'h5, 1,   0, 32'h0003FFFF);
    tbl[5]  = mk(1, 0, 32'h2000, 32'h0,        4'h0, 1,   0, 32'h00BBFFDD);
    tbl[6]  = mk(1, 1, 32'h2000, 32'hFFFFFFFF, 4'h0, 2,   0, 32'h00BBFFDD);
    tbl[7]  = mk(1, 0, 32'h2000, 32'h0,        4'h0, 1,   0, 32'h00BBFFDD);
    tbl[8]  = mk(1, 0, 32'h300,  32'h0,        4'h0, 255, 1, 32'h0);
    tbl[9]  = mk(0, 0, 32'h104,  32'h0,        4'h0, 255, 1, 32'h0);
    tbl[10] = mk(1, 0, 32'h10,   32'h0,        4'h0, 1,   0, 32'h0000000D);

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_outputs", 32'({if_done, if_err, d_done, d_err, mem_rd_en, mem_wr_en, mem_wstrb}), 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_rdata", if_rdata | d_rdata | mem_wdata, 32'h0);

    rsp_force = 1'b1;
    repeat (2) @(negedge clk);
    rsp_force = 1'b0;
    chk("stray_ready_ignored", 32'({if_done, d_done, mem_rd_en, mem_wr_en}), 32'h0);

    foreach (tbl[i]) run_txn(tbl[i], i);

    // Both requesters held: data streaks STARVE_LIMIT times, then fetch gets one.
    exp_ord = 10'b1111011110;
    got_ord = '0;
    ng = 0; pe = 0;
    rsp_dly = 1;
    if_req = 1; if_addr = 32'h500; d_req = 1; d_we = 0; d_addr = 32'h600;
    for (int c = 0; c < 200 && ng < 10; c++) begin
      @(negedge clk);
      en = mem_rd_en | mem_wr_en;
      if (en && !pe) begin
        got_ord[ng] = (mem_addr == 32'h600);
        ng++;
      end
      pe = en;
    end
    if_req = 0; d_req = 0;
    chk("grant_count", 32'(ng), 32'd10);
    for (int i = 0; i < 10; i++) chk($sformatf("grant_order_%0d", i), 32'(got_ord[i]), 32'(exp_ord[i]));
    repeat (5) @(negedge clk);

    // Fetch presented during DONE is granted right after the IDLE cycle.
    rsp_dly = 1;
    d_req = 1; d_we = 0; d_addr = 32'h10;
    seen_d = 0;
    for (int c = 0; c < 20 && !seen_d; c++) begin
      @(negedge clk);
      if (d_done) seen_d = 1;
    end
    chk("donephase_load_done", 32'(seen_d), 32'(1));
    chk("donephase_load_rdata", d_rdata, 32'h0000000D);
    d_req = 0; if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    chk("donephase_idle_gap", 32'({mem_rd_en, mem_wr_en}), 32'h0);
    @(negedge clk);
    chk("donephase_fetch_grant", 32'({mem_rd_en, mem_wr_en}), 32'h2);
    chk("donephase_fetch_addr", mem_addr, 32'h100);
    chk("donephase_d_rdata_kept", d_rdata, 32'h0000000D);
    seen_i = 0;
    for (int c = 0; c < 20 && !seen_i; c++) begin
      @(negedge clk);
      if (if_done) seen_i = 1;
    end
    if_req = 0;
    chk("donephase_fetch_done", 32'(seen_i), 32'(1));
    @(negedge clk);

    // Async reset in the middle of a hung load.
    rsp_dly = 255;
    d_req = 1; d_we = 0; d_addr = 32'h10;
    seen_d = 0;
    for (int c = 0; c < 20 && !seen_d; c++) begin
      @(negedge clk);
      if (mem_rd_en) seen_d = 1;
    end
    chk("rst_seq_load_started", 32'(seen_d), 32'(1));
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_enables", 32'({mem_rd_en, mem_wr_en}), 32'h0);
    chk("rst_async_addr", mem_addr, 32'h0);
    d_req = 0; if_req = 1; if_addr = 32'h100; rsp_dly = 1;
    @(negedge clk);
    rst = 1'b1;
    seen_d = 0; seen_i = 0;
    for (int c = 0; c < 20 && !seen_i; c++) begin
      @(negedge clk);
      if (d_done) seen_d = 1;
      if (if_done) seen_i = 1;
    end
    if_req = 0;
    chk("rst_no_d_done", 32'(seen_d), 32'(0));
    chk("rst_fetch_done", 32'(seen_i), 32'(1));
    chk("rst_fetch_rdata", if_rdata, 32'hDEADBEEF);
    chk("rst_fetch_err", 32'(if_err), 32'(0));
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the instruction-fetch requester and the load/store requester driven by control_unit.
- Arbitrates between the two requesters, drives one registered memory transaction at a time (mem_rd_en/mem_wr_en), waits for mem_ready and returns data with a one-cycle done pulse.
- Data accesses have priority. A streak limit prevents fetch starvation. A timeout aborts a hung access.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- STARVE_LIMIT, 4, maximum number of consecutive contested data grants before fetch wins
- TIMEOUT_CYCLES, 255, number of BUSY cycles without mem_ready before the access aborts

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- if_req  input  1  fetch request; held with if_addr until if_done
- if_addr  input  ADDR_WIDTH  fetch address
- if_rdata  output  DATA_WIDTH  fetched word; valid while if_done=1
- if_done  output  1  one-cycle completion pulse
- if_err  output  1  qualifies if_done: access timed out
- d_req  input  1  data request; held with d_* until d_done
- d_we  input  1  1=store, 0=load
- d_addr  input  ADDR_WIDTH  data address
- d_wdata  input  DATA_WIDTH  store data
- d_wstrb  input  DATA_WIDTH/8  byte strobes
- d_rdata  output  DATA_WIDTH  load data; valid while d_done=1
- d_done  output  1  one-cycle completion pulse
- d_err  output  1  qualifies d_done: access timed out
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_wstrb  output  DATA_WIDTH/8  memory byte strobes
- mem_rd_en  output  1  read strobe, level until mem_ready
- mem_wr_en  output  1  write strobe, level until mem_ready
- mem_rdata  input  DATA_WIDTH  memory read data, sampled with mem_ready
- mem_ready  input  1  memory completes the current access

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including mem_rd_en, mem_wr_en, done, err, rdata and mem_*.
  - streak and timeout counters clear.
  - An in-flight access is dropped; no done pulse follows.
- All outputs are registered.
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE grant rule:
  - Grant data if d_req && (!if_req || streak < STARVE_LIMIT).
  - Otherwise grant fetch if if_req.
  - Otherwise stay in IDLE.
- On grant, at the same edge:
  - Load mem_addr, mem_wdata and mem_wstrb. For a fetch, mem_wdata and mem_wstrb are 0.
  - Set mem_rd_en, or set mem_wr_en for a data store.
  - Go to BUSY_I or BUSY_D.
- streak update at each grant:
  - Data grant with if_req=1: increment, saturating at STARVE_LIMIT.
  - Data grant with if_req=0: clear to 0.
  - Fetch grant: clear to 0.
- BUSY_x:
  - mem_* hold stable; the timeout counter increments each cycle.
  - Edge with mem_ready=1:
    - Clear the enables.
    - For a read, capture mem_rdata into if_rdata or d_rdata.
    - Set done=1, err=0, go to DONE.
  - Edge where the counter reaches TIMEOUT_CYCLES with mem_ready=0:
    - Clear the enables and set done=1, err=1.
    - rdata for the read goes to 0.
    - Go to DONE.
- Stores never change d_rdata.
- DONE:
  - done/err are high for exactly this cycle; the next edge clears them and returns to IDLE.
  - The requester may present a new request during DONE. It is seen in IDLE.
- Minimum turnaround: 3 cycles. Request sampled in IDLE at edge 0, mem_ready high in the first BUSY cycle (sampled at edge 1), done high in the following cycle, next grant at edge 3.
- Requests that change address mid-transaction are ignored; mem_* stay as latched.
- Requests arriving in BUSY or DONE wait for IDLE; none are lost while held.
- mem_ready outside BUSY is ignored.
- d_wstrb is forwarded unchanged, including all-zero strobes; alignment is not checked.

Test Plan:
- Single fetch, if_addr=0x100, mem_ready one cycle after mem_rd_en, mem_rdata=0xDEADBEEF -> if_done pulses 1 cycle, if_rdata=0xDEADBEEF, if_err=0, mem_wr_en never high.
- Store, d_addr=0x2000, d_wdata=0x3FFFF, d_wstrb=4'hF, mem_ready after 3 cycles -> mem_wr_en high for exactly 3 cycles, mem_wdata=0x3FFFF, d_done pulse, d_rdata unchanged.
- d_req and if_req held continuously, new request each cycle after done, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- mem_ready held 0 with TIMEOUT_CYCLES=8 on a load -> d_done=1, d_err=1 and d_rdata=0 after 8 BUSY cycles; next request proceeds normally.
- rst asserted low mid-BUSY_D -> mem_rd_en/mem_wr_en drop asynchronously, no d_done; after release, a pending if_req is granted from IDLE.
- Load at 0x10 returns 0x0000000D, then a fetch is requested during DONE -> fetch granted the cycle after DONE, d_rdata keeps 0x0000000D.
